pipelined_carry_chain_adder: RTL and testbench

Parametrised, pipelined carry-chain adder/subtractor. It is the registered, streaming successor to the team's 4-bit ripple carry adders. The carry chain is cut into `STAGES` equal slices, and each slice's carry-out is registered into the next slice, so the full carry propagates across the whole width. Operands enter and results leave through valid/ready handshakes, for use in datapaths that need one add per clock at widths a single combinational ripple cannot close timing on.

---
 rtl/pipelined_carry_chain_adder_pkg.sv | 21 ++
 rtl/pipelined_carry_chain_adder_slice.sv | 29 ++
 rtl/pipelined_carry_chain_adder.sv | 130 +++++++++++++
 tb/tb_pipelined_carry_chain_adder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_carry_chain_adder_pkg.sv
// Shared definitions for the pipelined carry-chain adder: default geometry,
// geometry legality check and the per-stage control payload.
package adder_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;

  // Control half of a pipeline stage; the width-dependent data fields are
  // added by the user, which knows WIDTH.
  typedef struct packed {
    logic valid;
    logic sub;
    logic carry;
    logic c_msb;
  } stage_ctrl_t;

  function automatic bit cfg_legal(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_carry_chain_adder_slice.sv
// One SLICE-bit ripple of full adders; also reports the carry into its top
// bit so the last slice can form the signed-overflow flag.
module adder_slice
  import adder_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb_in
);

  always_comb begin
    logic [W:0] c;
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout     = c[W];
    c_msb_in = c[W-1];
  end

endmodule

// File: rtl/pipelined_carry_chain_adder.sv
// Streaming adder/subtractor whose carry chain is cut into STAGES registered
// slices; each stage finishes one slice and hands its carry to the next.
module pipelined_carry_chain_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int SLICE = WIDTH / STAGES;

  generate
    if (!cfg_legal(WIDTH, STAGES)) begin : g_cfg_err
      $error("pipelined_carry_chain_adder: WIDTH must be a multiple of STAGES");
    end
  endgenerate

  // sum holds completed low bits; a_rem/b_rem hold the unadded operand bits
  // shifted down so the next slice always reads bits [SLICE-1:0].
  typedef struct packed {
    stage_ctrl_t      ctrl;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
  } stage_t;

  stage_t            stage_q [STAGES];
  stage_t            stage_d [STAGES];
  logic [STAGES-1:0] adv;

  logic [SLICE-1:0] sl_a    [STAGES];
  logic [SLICE-1:0] sl_b    [STAGES];
  logic [SLICE-1:0] sl_s    [STAGES];
  logic             sl_cin  [STAGES];
  logic             sl_cout [STAGES];
  logic             sl_cmsb [STAGES];

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. A stage advances when empty or when its successor advances,
  // so in_ready depends only on valid bits and out_ready, never on in_valid.
  always_comb begin
    logic go;
    go  = out_ready;
    adv = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      go     = !stage_q[k].ctrl.valid || go;
      adv[k] = go;
    end
  end

  always_comb begin
    sl_a[0]   = a[SLICE-1:0];
    sl_b[0]   = b[SLICE-1:0] ^ {SLICE{sub}};
    sl_cin[0] = sub | cin;
    for (int k = 1; k < STAGES; k++) begin
      sl_a[k]   = stage_q[k-1].a_rem[SLICE-1:0];
      sl_b[k]   = stage_q[k-1].b_rem[SLICE-1:0] ^ {SLICE{stage_q[k-1].ctrl.sub}};
      sl_cin[k] = stage_q[k-1].ctrl.carry;
    end
  end

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_slice
      adder_slice #(.W(SLICE)) u_slice (
        .a        (sl_a[k]),
        .b        (sl_b[k]),
        .cin      (sl_cin[k]),
        .s        (sl_s[k]),
        .cout     (sl_cout[k]),
        .c_msb_in (sl_cmsb[k])
      );
    end
  endgenerate

  always_comb begin
    stage_d[0].ctrl.valid         = in_valid;
    stage_d[0].ctrl.sub           = sub;
    stage_d[0].ctrl.carry         = sl_cout[0];
    stage_d[0].ctrl.c_msb         = sl_cmsb[0];
    stage_d[0].sum                = '0;
    stage_d[0].sum[SLICE-1:0]     = sl_s[0];
    stage_d[0].a_rem              = a >> SLICE;
    stage_d[0].b_rem              = b >> SLICE;
    for (int k = 1; k < STAGES; k++) begin
      stage_d[k].ctrl.valid           = stage_q[k-1].ctrl.valid;
      stage_d[k].ctrl.sub             = stage_q[k-1].ctrl.sub;
      stage_d[k].ctrl.carry           = sl_cout[k];
      stage_d[k].ctrl.c_msb           = sl_cmsb[k];
      stage_d[k].sum                  = stage_q[k-1].sum;
      stage_d[k].sum[k*SLICE +: SLICE] = sl_s[k];
      stage_d[k].a_rem                = stage_q[k-1].a_rem >> SLICE;
      stage_d[k].b_rem                = stage_q[k-1].b_rem >> SLICE;
    end
  end

  // Bubbles only clear the valid bit, so the outputs keep the last result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          if (stage_d[k].ctrl.valid) stage_q[k] <= stage_d[k];
          else                       stage_q[k].ctrl.valid <= 1'b0;
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = stage_q[STAGES-1].ctrl.valid;
  assign sum       = stage_q[STAGES-1].sum;
  assign cout      = stage_q[STAGES-1].ctrl.carry;
  assign overflow  = stage_q[STAGES-1].ctrl.carry ^ stage_q[STAGES-1].ctrl.c_msb;

endmodule

// File: tb/tb_pipelined_carry_chain_adder.sv
// Self-checking bench for pipelined_carry_chain_adder at WIDTH=16, STAGES=4.
module tb_pipelined_carry_chain_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;

  pipelined_carry_chain_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          got_cnt  = 0;
  logic [17:0] exp_q[$];
  bit          hold_armed = 1'b0;
  logic [17:0] held;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: full-width add, overflow from the operand/result sign rule.
  function automatic logic [17:0] ref_result(input logic [15:0] ra, input logic [15:0] rb,
                                             input logic rc, input logic rs);
    logic [15:0] bb;
    logic [16:0] t;
    logic        ov;
    bb = rs ? ~rb : rb;
    t  = {1'b0, ra} + {1'b0, bb} + 17'(rs ? 1'b1 : rc);
    ov = (ra[15] == bb[15]) && (t[15] != ra[15]);
    return {t[16], ov, t[15:0]};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      hold_armed = 1'b0;
    end else begin
      if (hold_armed)
        check("stall_hold", 32'({out_valid, cout, overflow, sum}), 32'({1'b1, held}));
      hold_armed = out_valid && !out_ready;
      held       = {cout, overflow, sum};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_extra_out", 32'(out_valid), 32'(0));
        end else begin
          check("sb_result", 32'({cout, overflow, sum}), 32'(exp_q.pop_front()));
          got_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_one(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                          input logic vs, input logic [15:0] es, input logic ec,
                          input logic eo, input string tag);
    a = va; b = vb; cin = vc; sub = vs;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, " accept_rdy"}, 32'(in_ready), 32'(1));
    exp_q.push_back({ec, eo, es});
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check({tag, " lat_early"}, 32'(out_valid), 32'(0));
    @(posedge clk); #1;
    check({tag, " lat_valid"}, 32'(out_valid), 32'(1));
    check({tag, " sum"},       32'(sum),       32'(es));
    check({tag, " cout"},      32'(cout),      32'(ec));
    check({tag, " ovf"},       32'(overflow),  32'(eo));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          idx;
    int          inflight;
    bit          fire_in;
    bit          fire_out;
    bit          saw_block;
    logic [15:0] sa;
    logic [15:0] sb;
    logic        sc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", 32'(out_valid), 32'(0));
    check("rst sum",       32'(sum),       32'(0));
    check("rst cout",      32'(cout),      32'(0));
    check("rst ovf",       32'(overflow),  32'(0));
    rst = 1'b0;
    #1;
    check("rst in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;

    // Directed vectors with hand-computed results.
    send_one(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "add_00ff");
    send_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_ffff");
    send_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_7fff");
    send_one(16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, "sub_5m3");
    send_one(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_3m5");
    send_one(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_8000");
    send_one(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, "add_cin");
    idle(3);

    // Stream of 10 back-to-back sets with out_ready low on cycles 6..8.
    got_cnt   = 0;
    idx       = 0;
    inflight  = 0;
    saw_block = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      out_ready = !(cyc >= 6 && cyc <= 8);
      in_valid  = (idx < 10);
      sa = 16'(idx * 32'h1111);
      sb = 16'(idx);
      sc = sb[0];
      a = sa; b = sb; cin = sc; sub = 1'b0;
      @(negedge clk);
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      check("stream in_ready", 32'(in_ready), 32'((inflight < 4) || out_ready));
      if (!in_ready) saw_block = 1'b1;
      if (fire_in) begin
        exp_q.push_back(ref_result(sa, sb, sc, 1'b0));
        idx++;
      end
      inflight = inflight + int'(fire_in) - int'(fire_out);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("stream in_ready_drop", 32'(saw_block), 32'(1));
    check("stream count",         32'(got_cnt),   32'(10));
    check("stream queue_empty",   32'(exp_q.size()), 32'(0));
    idle(2);

    // Reset in the middle of traffic discards everything in flight.
    out_ready = 1'b0;
    a = 16'h1000; b = 16'h0234; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 16'h2000; b = 16'h0111;
    @(posedge clk); #1;
    a = 16'h3000; b = 16'h0222;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst out_valid", 32'(out_valid), 32'(1));
    check("pre_rst sum",       32'(sum),       32'(16'h1234));
    rst = 1'b1;
    #1;
    check("mid_rst out_valid", 32'(out_valid), 32'(0));
    check("mid_rst sum",       32'(sum),       32'(0));
    check("mid_rst cout",      32'(cout),      32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("post_rst in_ready", 32'(in_ready), 32'(1));
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("post_rst no_stale", 32'(out_valid), 32'(0));
    end
    send_one(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, "after_rst");
    idle(2);
    check("final queue_empty", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
